// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_responder wait-state data memory.
package dmem_pkg;

    localparam int DEFAULT_DEPTH       = 64;
    localparam int DEFAULT_WAIT_CYCLES = 2;
    localparam int CNT_W               = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/dmem_ram.sv
// Word-addressed data array: synchronous write, registered read, no reset.
module dmem_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // NOTE: the array and its read register carry no reset so they map onto block RAM;
    // the responder masks rdata until the first good read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data memory responder (IDLE -> WAIT -> RESP). Define DMEM_RESPONDER_ERR_EN
// to fault misaligned or out-of-range accesses; otherwise addresses wrap modulo DEPTH.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              rd_zero_q, rd_zero_d;

    logic              enter_resp;
    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic              fault;
    logic              ram_we;
    logic              ram_re;
    logic [31:0]       ram_rdata;

    // With no wait states the access completes on the capturing edge, so it must use the live inputs.
    assign acc_we    = (state_q == IDLE) ? we    : we_q;
    assign acc_addr  = (state_q == IDLE) ? addr  : addr_q;
    assign acc_wdata = (state_q == IDLE) ? wdata : wdata_q;

`ifdef DMEM_RESPONDER_ERR_EN
    assign fault = (acc_addr[1:0] != 2'b00) || (acc_addr >= 32'(4 * DEPTH));
`else
    logic unused_addr_bits;
    assign fault            = 1'b0;
    assign unused_addr_bits = ^{acc_addr[31:AW+2], acc_addr[1:0]};
`endif

    // NOTE: every signal gets a default before the case so no path leaves a latch behind.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rd_zero_d  = rd_zero_q;
        enter_resp = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        cnt_d      = '0;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (enter_resp) begin
            ack_d = 1'b1;
            err_d = fault;
            if (!acc_we) begin
                rd_zero_d = fault;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_zero_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rd_zero_q <= rd_zero_d;
        end
    end

    // Array strobes are gated by reset so an aborted or held-off access never reaches memory.
    assign ram_we = RST_n && enter_resp &&  acc_we && !fault;
    assign ram_re = RST_n && enter_resp && !acc_we && !fault;

    dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (CLK),
        .we    (ram_we),
        .re    (ram_re),
        .idx   (acc_addr[2 +: AW]),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    assign rdata = rd_zero_q ? 32'h0 : ram_rdata;
    assign ack   = ack_q;
    assign err   = err_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with WAIT_CYCLES=2, one with WAIT_CYCLES=0.
module tb_dmem_responder;

    logic        CLK;
    logic        RST_n;
    logic        req_a, req_b;
    logic        we_i;
    logic [31:0] addr_i, wdata_i;
    logic [31:0] rdata_a, rdata_b;
    logic        ack_a, ack_b, err_a, err_b, busy_a, busy_b;

    int n_total  = 0;
    int n_passed = 0;

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut_a (
        .CLK(CLK), .RST_n(RST_n), .req(req_a), .we(we_i), .addr(addr_i), .wdata(wdata_i),
        .rdata(rdata_a), .ack(ack_a), .err(err_a), .busy(busy_a)
    );

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut_b (
        .CLK(CLK), .RST_n(RST_n), .req(req_b), .we(we_i), .addr(addr_i), .wdata(wdata_i),
        .rdata(rdata_b), .ack(ack_b), .err(err_b), .busy(busy_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic ack_of(input int sel);
        return (sel == 0) ? ack_a : ack_b;
    endfunction

    // One full access; the address and data are disturbed right after capture.
    task automatic access(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_err, input string tag);
        int lat;
        int exp_lat;
        exp_lat = (sel == 0) ? 3 : 1;
        @(negedge CLK);
        we_i = w; addr_i = a; wdata_i = d;
        if (sel == 0) req_a = 1'b1; else req_b = 1'b1;
        @(posedge CLK);
        lat = 1;
        #1;
        req_a = 1'b0; req_b = 1'b0;
        addr_i = a ^ 32'h4; wdata_i = ~d; we_i = ~w;
        @(negedge CLK);
        check({tag, "_busy"}, {31'b0, (sel == 0) ? busy_a : busy_b}, 32'd1);
        while (!ack_of(sel) && lat <= 20) begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_err"}, {31'b0, (sel == 0) ? err_a : err_b}, {31'b0, exp_err});
        check({tag, "_rdata"}, (sel == 0) ? rdata_a : rdata_b, exp_rd);
        @(negedge CLK);
        check({tag, "_ack_pulse"}, {31'b0, ack_of(sel)}, 32'd0);
    endtask

    initial begin
        logic any_ack;

        vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h20,  32'hA0A0A0A0, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 32'h24,  32'hB4B4B4B4, 32'hDEADBEEF, 1'b0};
        vecs[4]  = '{1'b0, 32'h20,  32'h0,        32'hA0A0A0A0, 1'b0};
        vecs[5]  = '{1'b1, 32'h00,  32'h11111111, 32'hA0A0A0A0, 1'b0};
        vecs[6]  = '{1'b1, 32'hFC,  32'h22222222, 32'hA0A0A0A0, 1'b0};
        vecs[7]  = '{1'b0, 32'hFC,  32'h0,        32'h22222222, 1'b0};
        vecs[8]  = '{1'b1, 32'h08,  32'hCAFE0008, 32'h22222222, 1'b0};
`ifdef DMEM_RESPONDER_ERR_EN
        vecs[9]  = '{1'b1, 32'h02,  32'h33333333, 32'h22222222, 1'b1};
        vecs[10] = '{1'b0, 32'h100, 32'h0,        32'h0,        1'b1};
        vecs[11] = '{1'b0, 32'h00,  32'h0,        32'h11111111, 1'b0};
`else
        vecs[9]  = '{1'b1, 32'h02,  32'h33333333, 32'h22222222, 1'b0};
        vecs[10] = '{1'b0, 32'h100, 32'h0,        32'h33333333, 1'b0};
        vecs[11] = '{1'b0, 32'h00,  32'h0,        32'h33333333, 1'b0};
`endif
        vecs[12] = '{1'b0, 32'h08,  32'h0,        32'hCAFE0008, 1'b0};

        RST_n = 1'b0; req_a = 1'b0; req_b = 1'b0;
        we_i = 1'b0; addr_i = '0; wdata_i = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_rdata_a", rdata_a, 32'h0);
        check("rst_ack_a", {31'b0, ack_a}, 32'd0);
        check("rst_err_a", {31'b0, err_a}, 32'd0);
        check("rst_busy_a", {31'b0, busy_a}, 32'd0);
        check("rst_rdata_b", rdata_b, 32'h0);
        check("rst_ack_b", {31'b0, ack_b}, 32'd0);
        check("rst_busy_b", {31'b0, busy_b}, 32'd0);
        @(posedge CLK);
        #1 RST_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            access(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
                   vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Reset in the middle of a write's wait states aborts it.
        @(negedge CLK);
        we_i = 1'b1; addr_i = 32'h08; wdata_i = 32'h12345678; req_a = 1'b1;
        @(posedge CLK);
        #1 req_a = 1'b0;
        @(negedge CLK);
        check("abort_busy_before", {31'b0, busy_a}, 32'd1);
        RST_n = 1'b0;
        #1;
        check("abort_busy_async", {31'b0, busy_a}, 32'd0);
        check("abort_rdata_async", rdata_a, 32'h0);
        any_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            any_ack = any_ack | ack_a;
        end
        check("abort_no_ack", {31'b0, any_ack}, 32'd0);
        @(posedge CLK);
        #1 RST_n = 1'b1;
        access(0, 1'b0, 32'h08, 32'h0, 32'hCAFE0008, 1'b0, "abort_readback");

        // Zero wait states with req held high: ack every second cycle.
        access(1, 1'b1, 32'h44, 32'h0BAD0044, 32'h0, 1'b0, "b_prewrite");
        req_b = 1'b1; we_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            addr_i  = 32'h40 + 32'(4 * k);
            wdata_i = 32'h5000 + 32'(k);
            @(posedge CLK);
            @(negedge CLK);
            check($sformatf("stream_ack%0d", k), {31'b0, ack_b}, {31'b0, (k % 2 == 0)});
        end
        req_b = 1'b0;
        for (int k = 0; k < 8; k += 2) begin
            access(1, 1'b0, 32'h40 + 32'(4 * k), 32'h0, 32'h5000 + 32'(k), 1'b0,
                   $sformatf("stream_rd%0d", k));
        end
        access(1, 1'b0, 32'h44, 32'h0, 32'h0BAD0044, 1'b0, "stream_skipped");

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
